// File: rtl/data_mem_pkg.sv
// Shared types and constants for the stalling data-memory responder.
package data_mem_pkg;

  localparam int unsigned WORD_W          = 16;
  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned MAX_WORDS_LOG2  = ADDR_W - 1;
  localparam int unsigned DEFAULT_LATENCY = 4;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Request captured at acceptance; word is the byte address with bit 0 dropped.
  typedef struct packed {
    logic                      rd;
    logic                      wr;
    logic                      bad;
    logic [MAX_WORDS_LOG2-1:0] word;
    logic [WORD_W-1:0]         data;
  } req_t;

endpackage

// File: rtl/mem_word_array.sv
// Single-port word array: synchronous write, synchronous read into a held read register.
module mem_word_array #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register holds the last read word until the next read.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for memory-stage data requests: one request at a time, fixed latency,
// registered Stall/Done/err/DataOut.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned LATENCY    = DEFAULT_LATENCY,
  parameter int unsigned WORDS_LOG2 = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [WORD_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [WORD_W-1:0] DataOut,
  output logic              Stall,
  output logic              Done,
  output logic              err
);

  localparam bit SINGLE = (LATENCY == 1);

  state_e               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  req_t                 req_q, req_n, req_in;
  logic                 stall_n, done_n, err_n;
  logic                 mem_we, mem_re;
  logic [WORDS_LOG2-1:0] mem_word;
  logic [WORD_W-1:0]    mem_wdata;

  // Next-state, request capture and array strobes; the array access is issued
  // on the edge that enters DONE.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    req_n     = req_q;
    stall_n   = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_word  = req_q.word[WORDS_LOG2-1:0];
    mem_wdata = req_q.data;

    // Anything other than a clean single Rd or Wr on an even address (including X) is bad.
    req_in.rd   = Rd;
    req_in.wr   = Wr;
    req_in.bad  = 1'b1;
    req_in.word = Addr[ADDR_W-1:1];
    req_in.data = DataIn;
    if ((Rd ^ Wr) == 1'b1 && Addr[0] == 1'b0) req_in.bad = 1'b0;

    unique case (state)
      IDLE: begin
        if (Rd == 1'b0 && Wr == 1'b0) begin
          state_n = IDLE;
        end else begin
          req_n = req_in;
          cnt_n = CNT_W'(LATENCY - 1);
          if (SINGLE) begin
            state_n   = DONE;
            done_n    = 1'b1;
            err_n     = req_in.bad;
            mem_we    = req_in.wr & ~req_in.bad;
            mem_re    = req_in.rd & ~req_in.bad;
            mem_word  = req_in.word[WORDS_LOG2-1:0];
            mem_wdata = req_in.data;
          end else begin
            state_n = BUSY;
            stall_n = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = DONE;
          done_n  = 1'b1;
          err_n   = req_q.bad;
          mem_we  = req_q.wr & ~req_q.bad;
          mem_re  = req_q.rd & ~req_q.bad;
        end else begin
          stall_n = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      req_q <= '0;
      Stall <= 1'b0;
      Done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      req_q <= req_n;
      Stall <= stall_n;
      Done  <= done_n;
      err   <= err_n;
    end
  end

  // Reset on the completing edge drops the access.
  mem_word_array #(
    .ADDR_W (WORDS_LOG2),
    .DATA_W (WORD_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we & ~rst),
    .re    (mem_re & ~rst),
    .addr  (mem_word),
    .wdata (mem_wdata),
    .rdata (DataOut)
  );

endmodule
